// File: rtl/logic_reduce_pkg.sv
// Shared mode encodings, FSM states and operator helper
// for the framed logic-reduction block.
package logic_reduce_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  function automatic logic [1:0] base_op(
    input logic [1:0] m
  );
    return (m == MODE_NOR) ? MODE_OR : m;
  endfunction

endpackage

// File: rtl/logic_reduce_word.sv
// Combinational per-word reduction and popcount.
// Popcount exists only with LOGIC_REDUCE_ONES_EN.
import logic_reduce_pkg::*;

module logic_reduce_word #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]           data,
  input  logic [1:0]                 op,
  output logic                       red
`ifdef LOGIC_REDUCE_ONES_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] pop
`endif
);

  // reduce the word with the base operator
  always_comb begin
    red = 1'b0;
    case (op)
      MODE_AND: red = &data;
      MODE_XOR: red = ^data;
      default:  red = |data;
    endcase
  end

`ifdef LOGIC_REDUCE_ONES_EN
  localparam int PW = $clog2(WIDTH+1);

  // count the set bits of the word
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(data[i]);
    end
  end
`endif

endmodule

// File: rtl/logic_reduce_frame.sv
// Frame-wise OR/AND/XOR/NOR reduction with valid/ready I/O.
// Optional out_ones popcount: LOGIC_REDUCE_ONES_EN.
import logic_reduce_pkg::*;

module logic_reduce_frame #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
`ifdef LOGIC_REDUCE_ONES_EN
  ,
  output logic [CNT_W+$clog2(WIDTH+1)-1:0] out_ones
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       mode_q, mode_d;
  logic             ov_q, ov_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             oovf_q, oovf_d;

  logic       accept;
  logic       first;
  logic [1:0] mode_eff;
  logic [1:0] op;
  logic       red;

  assign in_ready  = (state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign first     = (cnt_q == '0);
  assign mode_eff  = first ? mode : mode_q;
  assign op        = base_op(mode_eff);
  assign out_valid = ov_q;
  assign out_y     = y_q;
  assign out_beats = beats_q;
  assign out_ovf   = oovf_q;

`ifdef LOGIC_REDUCE_ONES_EN
  localparam int PW  = $clog2(WIDTH+1);
  localparam int OW  = CNT_W + PW;
  localparam int OW1 = OW + 1;

  logic [PW-1:0] pop;
  logic [OW-1:0] ones_q, ones_d;
  logic [OW-1:0] oones_q, oones_d;
  logic [OW:0]   ones_sum;

  assign out_ones = oones_q;

  logic_reduce_word #(.WIDTH(WIDTH)) u_word (
    .data (in_data),
    .op   (op),
    .red  (red),
    .pop  (pop)
  );
`else
  logic_reduce_word #(.WIDTH(WIDTH)) u_word (
    .data (in_data),
    .op   (op),
    .red  (red)
  );
`endif

  // next state: accumulate beats, emit result, wait for consumer
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    ov_d    = ov_q;
    y_d     = y_q;
    beats_d = beats_q;
    oovf_d  = oovf_q;
`ifdef LOGIC_REDUCE_ONES_EN
    ones_d   = ones_q;
    oones_d  = oones_q;
    ones_sum = {1'b0, ones_q} + OW1'(pop);
`endif
    case (state_q)
      ACC: begin
        if (accept) begin
          mode_d = mode_eff;
          if (first) begin
            acc_d = red;
          end else begin
            case (op)
              MODE_AND: acc_d = acc_q & red;
              MODE_XOR: acc_d = acc_q ^ red;
              default:  acc_d = acc_q | red;
            endcase
          end
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`ifdef LOGIC_REDUCE_ONES_EN
          if (first) begin
            ones_d = OW'(pop);
          end else begin
            ones_d = ones_sum[OW] ? '1 : ones_sum[OW-1:0];
          end
`endif
          if (in_last) begin
            state_d = OUT;
            ov_d    = 1'b1;
            y_d     = acc_d ^ (mode_eff == MODE_NOR);
            beats_d = cnt_d;
            oovf_d  = ovf_d;
`ifdef LOGIC_REDUCE_ONES_EN
            oones_d = ones_d;
`endif
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = ACC;
          ov_d    = 1'b0;
          acc_d   = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef LOGIC_REDUCE_ONES_EN
          ones_d  = '0;
`endif
        end
      end
      default: state_d = ACC;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= MODE_OR;
      ov_q    <= 1'b0;
      y_q     <= 1'b0;
      beats_q <= '0;
      oovf_q  <= 1'b0;
`ifdef LOGIC_REDUCE_ONES_EN
      ones_q  <= '0;
      oones_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
      y_q     <= y_d;
      beats_q <= beats_d;
      oovf_q  <= oovf_d;
`ifdef LOGIC_REDUCE_ONES_EN
      ones_q  <= ones_d;
      oones_q <= oones_d;
`endif
    end
  end

endmodule

// File: tb/tb_logic_reduce_frame.sv
// Bench for logic_reduce_frame (WIDTH=3, CNT_W=2) with a
// frame-level model built from total set-bit counts.
`timescale 1ns/1ps

module tb_logic_reduce_frame;

  localparam int W  = 3;
  localparam int C  = 2;
  localparam int OW = C + $clog2(W+1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic         out_y;
  logic [C-1:0] out_beats;
  logic         out_ovf;
`ifdef LOGIC_REDUCE_ONES_EN
  logic [OW-1:0] out_ones;
`endif

  int vectors = 0;
  int errors  = 0;

  logic_reduce_frame #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_beats (out_beats),
    .out_ovf   (out_ovf)
`ifdef LOGIC_REDUCE_ONES_EN
    ,
    .out_ones  (out_ones)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  // Frame model: n beats, t total set bits, m = mode of first beat.
  function automatic void model(
    input  int         n,
    input  int         t,
    input  logic [1:0] m,
    output logic       y,
    output int         beats,
    output logic       ovf,
    output int         ones
  );
    int maxc;
    int maxo;
    maxc = (1 << C) - 1;
    maxo = (1 << OW) - 1;
    case (m)
      2'd0:    y = (t > 0);
      2'd1:    y = (t == n * W);
      2'd2:    y = (t % 2) == 1;
      default: y = (t == 0);
    endcase
    beats = (n > maxc) ? maxc : n;
    ovf   = (n > maxc);
    ones  = (t > maxo) ? maxo : t;
  endfunction

  task automatic send_beat(
    input logic [W-1:0] d,
    input logic [1:0]   m,
    input logic         last
  );
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    in_last  = last;
    for (int k = 0; k < 64 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output logic got);
    for (int k = 0; k < 64 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    got = out_valid;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    mode      = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %0b want 0", out_valid);
    end
    vectors++;
    if (out_y !== 1'b0 || out_beats !== '0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_outs: got y=%0b b=%0d o=%0b want 0 0 0",
               out_y, out_beats, out_ovf);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %0b want 1", in_ready);
    end
`ifdef LOGIC_REDUCE_ONES_EN
    vectors++;
    if (out_ones !== '0) begin
      errors++;
      $display("FAIL rst_ones: got %0d want 0", out_ones);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_legacy();
    out_ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      send_beat(W'(d), 2'b00, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_y !== (d != 0) || out_beats !== C'(1)) begin
        errors++;
        $display("FAIL legacy_%0d: got v=%0b y=%0b b=%0d want 1 %0b 1",
                 d, out_valid, out_y, out_beats, (d != 0));
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_multi();
    logic got;
    send_beat(3'b111, 2'b01, 1'b0);
    send_beat(3'b111, 2'b01, 1'b0);
    send_beat(3'b110, 2'b01, 1'b1);
    wait_result(got);
    vectors++;
    if (!got || out_y !== 1'b0 || out_beats !== C'(3)) begin
      errors++;
      $display("FAIL multi_and: got v=%0b y=%0b b=%0d want 1 0 3",
               got, out_y, out_beats);
    end
`ifdef LOGIC_REDUCE_ONES_EN
    vectors++;
    if (out_ones !== OW'(8)) begin
      errors++;
      $display("FAIL multi_and_ones: got %0d want 8", out_ones);
    end
`endif
    release_result();
    send_beat(3'b001, 2'b10, 1'b0);
    send_beat(3'b011, 2'b10, 1'b0);
    send_beat(3'b111, 2'b10, 1'b1);
    wait_result(got);
    vectors++;
    if (!got || out_y !== 1'b0 || out_beats !== C'(3)) begin
      errors++;
      $display("FAIL multi_xor: got v=%0b y=%0b b=%0d want 1 0 3",
               got, out_y, out_beats);
    end
`ifdef LOGIC_REDUCE_ONES_EN
    vectors++;
    if (out_ones !== OW'(6)) begin
      errors++;
      $display("FAIL multi_xor_ones: got %0d want 6", out_ones);
    end
`endif
    release_result();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(3'b101, 2'b00, 1'b1);
    in_valid = 1'b1;
    in_data  = 3'b000;
    in_last  = 1'b1;
    mode     = 2'b00;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_y !== 1'b1 || out_beats !== C'(1)) begin
        errors++;
        $display("FAIL bp_hold_%0d: got r=%0b v=%0b y=%0b b=%0d want 0 1 1 1",
                 c, in_ready, out_valid, out_y, out_beats);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got r=%0b v=%0b want 1 0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 1'b0 || out_beats !== C'(1)) begin
      errors++;
      $display("FAIL bp_next: got v=%0b y=%0b b=%0d want 1 0 1",
               out_valid, out_y, out_beats);
    end
    release_result();
  endtask

  task automatic test_mode_latch();
    logic got;
    send_beat(3'b000, 2'b11, 1'b0);
    send_beat(3'b000, 2'b00, 1'b0);
    send_beat(3'b000, 2'b00, 1'b1);
    wait_result(got);
    vectors++;
    if (!got || out_y !== 1'b1 || out_beats !== C'(3) || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mode_latch: got v=%0b y=%0b b=%0d o=%0b want 1 1 3 0",
               got, out_y, out_beats, out_ovf);
    end
    release_result();
  endtask

  task automatic test_saturation();
    logic got;
    logic [W-1:0] w;
    int t;
    logic ey;
    int eb;
    logic eo;
    int en;
    t = 0;
    for (int i = 0; i < 6; i++) begin
      w = W'($urandom_range(0, 7));
      t += $countones(w);
      send_beat(w, 2'b00, i == 5);
    end
    model(6, t, 2'b00, ey, eb, eo, en);
    wait_result(got);
    vectors++;
    if (!got || out_beats !== C'(eb) || out_ovf !== 1'b1 || out_y !== ey) begin
      errors++;
      $display("FAIL sat: got v=%0b b=%0d o=%0b y=%0b want 1 %0d 1 %0b",
               got, out_beats, out_ovf, out_y, eb, ey);
    end
    release_result();
    send_beat(3'b111, 2'b01, 1'b1);
    wait_result(got);
    vectors++;
    if (!got || out_ovf !== 1'b0 || out_beats !== C'(1) || out_y !== 1'b1) begin
      errors++;
      $display("FAIL sat_clear: got v=%0b o=%0b b=%0d y=%0b want 1 0 1 1",
               got, out_ovf, out_beats, out_y);
    end
    release_result();
  endtask

  task automatic test_random();
    logic got;
    logic [W-1:0] w;
    logic [1:0] m0;
    int n;
    int t;
    logic ey;
    int eb;
    logic eo;
    int en;
    for (int f = 0; f < 40; f++) begin
      n  = $urandom_range(1, 6);
      m0 = 2'($urandom_range(0, 3));
      t  = 0;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          in_data = W'($urandom_range(0, 7));
          mode    = 2'($urandom_range(0, 3));
          @(posedge clk); #1;
        end
        w = W'($urandom_range(0, 7));
        t += $countones(w);
        send_beat(w, (i == 0) ? m0 : 2'($urandom_range(0, 3)), i == n - 1);
      end
      model(n, t, m0, ey, eb, eo, en);
      wait_result(got);
      vectors++;
      if (!got || out_y !== ey || out_beats !== C'(eb) || out_ovf !== eo) begin
        errors++;
        $display("FAIL rand_%0d: got v=%0b y=%0b b=%0d o=%0b want 1 %0b %0d %0b",
                 f, got, out_y, out_beats, out_ovf, ey, eb, eo);
      end
`ifdef LOGIC_REDUCE_ONES_EN
      vectors++;
      if (out_ones !== OW'(en)) begin
        errors++;
        $display("FAIL rand_ones_%0d: got %0d want %0d", f, out_ones, en);
      end
`endif
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      release_result();
    end
  endtask

  task automatic test_async_reset();
    logic got;
    out_ready = 1'b0;
    send_beat(3'b010, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_y !== 1'b0 ||
        out_beats !== '0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL arst_out: got v=%0b y=%0b b=%0d o=%0b want 0 0 0 0",
               out_valid, out_y, out_beats, out_ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(3'b111, 2'b01, 1'b0);
    send_beat(3'b111, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_mid: got v=%0b r=%0b want 0 1",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(3'b100, 2'b00, 1'b1);
    wait_result(got);
    vectors++;
    if (!got || out_y !== 1'b1 || out_beats !== C'(1) || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL arst_next: got v=%0b y=%0b b=%0d o=%0b want 1 1 1 0",
               got, out_y, out_beats, out_ovf);
    end
`ifdef LOGIC_REDUCE_ONES_EN
    vectors++;
    if (out_ones !== OW'(1)) begin
      errors++;
      $display("FAIL arst_ones: got %0d want 1", out_ones);
    end
`endif
    release_result();
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_multi();
    test_backpressure();
    test_mode_latch();
    test_saturation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
